// File: rtl/io_handshake_port_if.sv
// Purpose: CPU register bus and external four-phase device handshake for io_handshake_port.
// Signals:
//   device input  : in, inDataReady (to port), inACK (from port)
//   device output : out, outDataReady (from port), outACK (to port)
//   cpu           : cpu_wr, cpu_wdata, cpu_rd, clr_err (to port);
//                   cpu_rdata, status, irq (from port)
// Modports: slave = the port itself, master = CPU plus external device.
interface io_handshake_port_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] in;
    logic              inDataReady;
    logic              inACK;
    logic [DATA_W-1:0] out;
    logic              outDataReady;
    logic              outACK;
    logic              cpu_wr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rd;
    logic [DATA_W-1:0] cpu_rdata;
    logic [3:0]        status;
    logic              clr_err;
    logic              irq;

    modport master (
        output in, inDataReady, outACK, cpu_wr, cpu_wdata, cpu_rd, clr_err,
        input  inACK, out, outDataReady, cpu_rdata, status, irq
    );

    modport slave (
        input  in, inDataReady, outACK, cpu_wr, cpu_wdata, cpu_rd, clr_err,
        output inACK, out, outDataReady, cpu_rdata, status, irq
    );
endinterface

// File: rtl/io_handshake_port.sv
// Purpose: buffered processor I/O port. An input FIFO is filled from an external
// device over a four-phase ready/ack handshake and drained by CPU reads; an output
// FIFO is filled by CPU writes and drained to the device over a second handshake.
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset, flushes both FIFOs and aborts handshakes
//   port_io : io_handshake_port_if.slave (device handshakes, CPU bus, status, irq)
// status = {ovf, unf, out_full, in_empty}; ovf/unf are sticky, cleared by clr_err.
// Optional feature macro: IO_PORT_IRQ_EN (level irq on input occupancy or tx-done);
// when undefined irq is tied low.
module io_handshake_port #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IN_DEPTH   = 4,
    parameter int unsigned OUT_DEPTH  = 4,
    parameter int unsigned IRQ_THRESH = 1
) (
    input logic                 clk,
    input logic                 reset,
    io_handshake_port_if.slave  port_io
);
    localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
    localparam int unsigned IN_CW  = IN_AW + 1;
    localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
    localparam int unsigned OUT_CW = OUT_AW + 1;

    // Elaboration-time parameter sanity checks.
    if (IN_DEPTH < 2 || OUT_DEPTH < 2) begin : g_bad_depth
        $error("io_handshake_port: FIFO depths must be >= 2");
    end
    if (IRQ_THRESH < 1 || IRQ_THRESH > IN_DEPTH) begin : g_bad_thresh
        $error("io_handshake_port: IRQ_THRESH must be in 1..IN_DEPTH");
    end

    typedef enum logic {I_IDLE, I_ACK} in_state_e;
    typedef enum logic [1:0] {O_IDLE, O_VALID, O_WAITLOW} out_state_e;

    in_state_e  in_state_q, in_state_d;
    out_state_e out_state_q, out_state_d;

    logic [DATA_W-1:0] in_mem_q  [IN_DEPTH];
    logic [DATA_W-1:0] out_mem_q [OUT_DEPTH];
    logic [IN_AW-1:0]  in_wr_ptr_q, in_rd_ptr_q;
    logic [OUT_AW-1:0] out_wr_ptr_q, out_rd_ptr_q;
    logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;
    logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;

    logic              inack_q, inack_d;
    logic              odr_q, odr_d;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ovf_q, ovf_d, unf_q, unf_d;

    logic in_full_c, in_empty_c, out_full_c, out_empty_c;
    logic in_push_c, in_pop_c, out_push_c, out_pop_c, out_load_c;
    logic ovf_set_c, unf_set_c;

    assign in_full_c   = (in_cnt_q == IN_CW'(IN_DEPTH));
    assign in_empty_c  = (in_cnt_q == '0);
    assign out_full_c  = (out_cnt_q == OUT_CW'(OUT_DEPTH));
    assign out_empty_c = (out_cnt_q == '0);

    // CPU side: a read on empty or a write on full (without a freeing pop) is an error.
    assign in_pop_c   = port_io.cpu_rd && !in_empty_c;
    assign unf_set_c  = port_io.cpu_rd && in_empty_c;
    assign out_push_c = port_io.cpu_wr && (!out_full_c || out_pop_c);
    assign ovf_set_c  = port_io.cpu_wr && out_full_c && !out_pop_c;

    assign in_cnt_d  = in_cnt_q + IN_CW'(in_push_c) - IN_CW'(in_pop_c);
    assign out_cnt_d = out_cnt_q + OUT_CW'(out_push_c) - OUT_CW'(out_pop_c);

    // Input handshake FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state_q <= I_IDLE;
            inack_q    <= 1'b0;
        end else begin
            in_state_q <= in_state_d;
            inack_q    <= inack_d;
        end
    end

    // Input handshake FSM: next state; a full FIFO simply stalls the device.
    always_comb begin
        in_state_d = in_state_q;
        case (in_state_q)
            I_IDLE:  if (port_io.inDataReady && !in_full_c) in_state_d = I_ACK;
            I_ACK:   if (!port_io.inDataReady) in_state_d = I_IDLE;
            default: in_state_d = I_IDLE;
        endcase
    end

    // Input handshake FSM: outputs.
    always_comb begin
        in_push_c = (in_state_q == I_IDLE) && (in_state_d == I_ACK);
        inack_d   = (in_state_d == I_ACK);
    end

    // Output handshake FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_state_q <= O_IDLE;
            odr_q       <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            odr_q       <= odr_d;
        end
    end

    // Output handshake FSM: next state.
    always_comb begin
        out_state_d = out_state_q;
        case (out_state_q)
            O_IDLE:    if (!out_empty_c) out_state_d = O_VALID;
            O_VALID:   if (port_io.outACK) out_state_d = O_WAITLOW;
            O_WAITLOW: if (!port_io.outACK) out_state_d = O_IDLE;
            default:   out_state_d = O_IDLE;
        endcase
    end

    // Output handshake FSM: outputs. Head stays in the FIFO until acknowledged.
    always_comb begin
        out_load_c = (out_state_q == O_IDLE) && (out_state_d == O_VALID);
        out_pop_c  = (out_state_q == O_VALID) && port_io.outACK;
        odr_d      = (out_state_d == O_VALID);
    end

    // Sticky error flags: a same-cycle set wins over clr_err.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (port_io.clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ovf_set_c) ovf_d = 1'b1;
        if (unf_set_c) unf_d = 1'b1;
    end

    // FIFO storage; contents need no reset since pointers/counts are flushed.
    always_ff @(posedge clk) begin
        if (in_push_c)  in_mem_q[in_wr_ptr_q]   <= port_io.in;
        if (out_push_c) out_mem_q[out_wr_ptr_q] <= port_io.cpu_wdata;
    end

    // FIFO pointers, counts, data registers and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_cnt_q     <= '0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_cnt_q    <= '0;
            out_q        <= '0;
            rdata_q      <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            if (in_push_c) in_wr_ptr_q <= in_wr_ptr_q + IN_AW'(1);
            if (in_pop_c) begin
                in_rd_ptr_q <= in_rd_ptr_q + IN_AW'(1);
                rdata_q     <= in_mem_q[in_rd_ptr_q];
            end
            if (out_push_c) out_wr_ptr_q <= out_wr_ptr_q + OUT_AW'(1);
            if (out_pop_c)  out_rd_ptr_q <= out_rd_ptr_q + OUT_AW'(1);
            if (out_load_c) out_q        <= out_mem_q[out_rd_ptr_q];
        end
    end

`ifdef IO_PORT_IRQ_EN
    logic irq_q, irq_d, txdone_q, txdone_d, out_busy_q;

    // tx-done marks the output FIFO draining empty; new writes or clr_err rearm it.
    always_comb begin
        txdone_d = txdone_q;
        if (port_io.cpu_wr || port_io.clr_err) begin
            txdone_d = 1'b0;
        end else if (out_busy_q && out_empty_c) begin
            txdone_d = 1'b1;
        end
        irq_d = (in_cnt_d >= IN_CW'(IRQ_THRESH)) || txdone_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q      <= 1'b0;
            txdone_q   <= 1'b0;
            out_busy_q <= 1'b0;
        end else begin
            irq_q      <= irq_d;
            txdone_q   <= txdone_d;
            out_busy_q <= !out_empty_c;
        end
    end

    assign port_io.irq = irq_q;
`else
    assign port_io.irq = 1'b0;
`endif

    assign port_io.inACK        = inack_q;
    assign port_io.outDataReady = odr_q;
    assign port_io.out          = out_q;
    assign port_io.cpu_rdata    = rdata_q;
    assign port_io.status       = {ovf_q, unf_q, out_full_c, in_empty_c};
endmodule

// File: tb/tb_io_handshake_port.sv
// Bench for io_handshake_port: reset table, directed handshake sequences and a
// randomized run against a queue-based reference model.
module tb_io_handshake_port;
    localparam int unsigned DW    = 8;
    localparam int unsigned ID    = 4;
    localparam int unsigned OD    = 4;
    localparam int unsigned IRQ_T = 2;
`ifdef IO_PORT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    io_handshake_port_if #(.DATA_W(DW)) bus ();

    io_handshake_port #(
        .DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD), .IRQ_THRESH(IRQ_T)
    ) dut (
        .clk(clk), .reset(reset), .port_io(bus)
    );

    typedef struct {
        logic       idr;   logic [7:0] idata; logic oack;
        logic       wr;    logic [7:0] wdata; logic rd; logic clr;
        logic       e_inack; logic e_odr; logic [7:0] e_out;
        logic [7:0] e_rdata; logic [3:0] e_status;
    } vec_t;

    vec_t vt[15];

    // random stimulus for the current cycle
    logic       r_idr, r_oack, r_wr, r_rd, r_clr;
    logic [7:0] r_idata, r_wdata;

    // reference model: FIFO contents as queues, handshakes as protocol phases
    logic [7:0] m_in[$];
    logic [7:0] m_out[$];
    bit         m_in_busy;
    int         m_ophase;   // 0 waiting for data, 1 presenting, 2 waiting for ack release
    logic [7:0] m_outv, m_rdata;
    bit         m_ovf, m_unf, m_txd, m_prev_ne, m_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in = '0; bus.inDataReady = 1'b0; bus.outACK = 1'b0;
        bus.cpu_wr = 1'b0; bus.cpu_wdata = '0; bus.cpu_rd = 1'b0; bus.clr_err = 1'b0;
    endtask

    task automatic model_clear();
        m_in.delete(); m_out.delete();
        m_in_busy = 0; m_ophase = 0; m_outv = '0; m_rdata = '0;
        m_ovf = 0; m_unf = 0; m_txd = 0; m_prev_ne = 0; m_irq = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_clear();
    endtask

    function automatic vec_t mk(input logic idr, input logic [7:0] idata, input logic oack,
                                input logic wr, input logic [7:0] wdata, input logic rd,
                                input logic clr, input logic ei, input logic eo,
                                input logic [7:0] eout, input logic [7:0] erd,
                                input logic [3:0] est);
        vec_t v;
        v.idr = idr; v.idata = idata; v.oack = oack; v.wr = wr; v.wdata = wdata;
        v.rd = rd; v.clr = clr; v.e_inack = ei; v.e_odr = eo; v.e_out = eout;
        v.e_rdata = erd; v.e_status = est;
        return v;
    endfunction

    task automatic wait_inack(input logic v, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.inACK === v) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_odr(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.outDataReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Full four-phase input transfer of one word from the device.
    task automatic send_word(input logic [7:0] w, output bit ok);
        bit a, b;
        bus.in = w; bus.inDataReady = 1'b1;
        wait_inack(1'b1, a);
        bus.inDataReady = 1'b0;
        wait_inack(1'b0, b);
        ok = a && b;
    endtask

    task automatic cpu_read();
        bus.cpu_rd = 1'b1; step(); bus.cpu_rd = 1'b0;
    endtask

    // Advance the model by one clock edge using this cycle's stimulus.
    task automatic model_step();
        bit in_empty, in_full, out_empty, out_full, accept, pop_o;
        in_empty  = (m_in.size() == 0);
        in_full   = (m_in.size() == ID);
        out_empty = (m_out.size() == 0);
        out_full  = (m_out.size() == OD);
        accept    = !m_in_busy && r_idr && !in_full;
        if (m_in_busy) m_in_busy = r_idr;
        else           m_in_busy = accept;
        if (r_rd && !in_empty) m_rdata = m_in.pop_front();
        if (accept) m_in.push_back(r_idata);
        if (r_rd && in_empty) m_unf = 1; else if (r_clr) m_unf = 0;
        pop_o = (m_ophase == 1) && r_oack;
        if (m_ophase == 0 && !out_empty) begin
            m_outv = m_out[0];
            m_ophase = 1;
        end else if (pop_o) begin
            void'(m_out.pop_front());
            m_ophase = 2;
        end else if (m_ophase == 2 && !r_oack) begin
            m_ophase = 0;
        end
        if (r_wr && (!out_full || pop_o)) m_out.push_back(r_wdata);
        if (r_wr && out_full && !pop_o) m_ovf = 1; else if (r_clr) m_ovf = 0;
        if (r_wr || r_clr) m_txd = 0; else if (m_prev_ne && out_empty) m_txd = 1;
        m_prev_ne = !out_empty;
        m_irq = IRQ_ON && ((m_in.size() >= IRQ_T) || m_txd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, seen;
        logic [7:0] wa[5];
        reset = 1'b0;
        idle_inputs();

        // ---- reset state ----
        do_reset();
        chk("rst_inack", 32'(bus.inACK), 0);
        chk("rst_odr", 32'(bus.outDataReady), 0);
        chk("rst_rdata", 32'(bus.cpu_rdata), 0);
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_status", 32'(bus.status), 32'h1);
        chk("rst_irq", 32'(bus.irq), 0);

        // ---- table: 0x5A transfer, read, underflow, clear, output handshake ----
        vt[0]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00, 4'b0001);
        vt[1]  = mk(1, 8'h5A, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 8'h00, 4'b0000);
        vt[2]  = mk(1, 8'h5A, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 8'h00, 4'b0000);
        vt[3]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00, 4'b0000);
        vt[4]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 0,  0, 0, 8'h00, 8'h5A, 4'b0001);
        vt[5]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 0,  0, 0, 8'h00, 8'h5A, 4'b0101);
        vt[6]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 8'h00, 8'h5A, 4'b0001);
        vt[7]  = mk(0, 8'h00, 0, 1, 8'h11, 0, 0,  0, 0, 8'h00, 8'h5A, 4'b0001);
        vt[8]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 1, 8'h11, 8'h5A, 4'b0001);
        vt[9]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 0,  0, 0, 8'h11, 8'h5A, 4'b0001);
        vt[10] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0,  0, 0, 8'h11, 8'h5A, 4'b0001);
        vt[11] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 8'h11, 8'h5A, 4'b0001);
        vt[12] = mk(0, 8'h00, 0, 1, 8'h22, 1, 0,  0, 0, 8'h11, 8'h5A, 4'b0101);
        vt[13] = mk(0, 8'h00, 0, 0, 8'h00, 1, 1,  0, 1, 8'h22, 8'h5A, 4'b0101);
        vt[14] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 1, 8'h22, 8'h5A, 4'b0001);
        for (int i = 0; i < 15; i++) begin
            bus.inDataReady = vt[i].idr; bus.in = vt[i].idata; bus.outACK = vt[i].oack;
            bus.cpu_wr = vt[i].wr; bus.cpu_wdata = vt[i].wdata;
            bus.cpu_rd = vt[i].rd; bus.clr_err = vt[i].clr;
            step();
            chk($sformatf("vec%0d_inack", i), 32'(bus.inACK), 32'(vt[i].e_inack));
            chk($sformatf("vec%0d_odr", i), 32'(bus.outDataReady), 32'(vt[i].e_odr));
            chk($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vt[i].e_out));
            chk($sformatf("vec%0d_rdata", i), 32'(bus.cpu_rdata), 32'(vt[i].e_rdata));
            chk($sformatf("vec%0d_status", i), 32'(bus.status), 32'(vt[i].e_status));
        end
        idle_inputs();

        // ---- reset mid-handshake aborts both directions ----
        bus.in = 8'h77; bus.inDataReady = 1'b1;
        step();
        chk("mid_inack_pre", 32'(bus.inACK), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_inack", 32'(bus.inACK), 0);
        chk("mid_odr", 32'(bus.outDataReady), 0);
        chk("mid_status", 32'(bus.status), 32'h1);
        chk("mid_out", 32'(bus.out), 0);

        // ---- output overflow: five writes, no ack ----
        do_reset();
        wa[0] = 8'h11; wa[1] = 8'h22; wa[2] = 8'h33; wa[3] = 8'h44; wa[4] = 8'h55;
        bus.cpu_wr = 1'b1;
        bus.cpu_wdata = wa[0]; step();
        bus.cpu_wdata = wa[1]; step();
        chk("ovf_first_odr", 32'(bus.outDataReady), 1);
        chk("ovf_first_out", 32'(bus.out), 32'h11);
        bus.cpu_wdata = wa[2]; step();
        bus.cpu_wdata = wa[3]; step();
        chk("ovf_full_status", 32'(bus.status), 32'b0011);
        bus.cpu_wdata = wa[4]; step();
        bus.cpu_wr = 1'b0;
        chk("ovf_status", 32'(bus.status), 32'b1011);
        for (int k = 0; k < 4; k++) begin
            wait_odr(ok);
            chk($sformatf("ovf_odr_wait%0d", k), 32'(ok), 1);
            chk($sformatf("ovf_word%0d", k), 32'(bus.out), 32'(wa[k]));
            bus.outACK = 1'b1; step();
            bus.outACK = 1'b0; step();
        end
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen |= bus.outDataReady;
            step();
        end
        chk("ovf_no_fifth", 32'(seen), 0);
        chk("ovf_out_hold", 32'(bus.out), 32'h44);
        chk("ovf_drained_status", 32'(bus.status), 32'b1001);

        // ---- input full: fifth word stalls until one cpu_rd ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_word(8'(8'hA0 + k), ok);
            chk($sformatf("full_send%0d", k), 32'(ok), 1);
        end
        bus.in = 8'hA4; bus.inDataReady = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            seen |= bus.inACK;
        end
        chk("full_hold", 32'(seen), 0);
        cpu_read();
        chk("full_rd0", 32'(bus.cpu_rdata), 32'hA0);
        wait_inack(1'b1, ok);
        chk("full_accept", 32'(ok), 1);
        bus.inDataReady = 1'b0;
        wait_inack(1'b0, ok);
        chk("full_release", 32'(ok), 1);
        for (int k = 1; k < 5; k++) begin
            cpu_read();
            chk($sformatf("full_rd%0d", k), 32'(bus.cpu_rdata), 32'(8'hA0 + k));
        end
        chk("full_empty_status", 32'(bus.status), 32'b0001);
        cpu_read();
        chk("unf_rdata_hold", 32'(bus.cpu_rdata), 32'hA4);
        chk("unf_status", 32'(bus.status), 32'b0101);
        bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
        chk("unf_clear", 32'(bus.status), 32'b0001);

        // ---- irq threshold ----
        do_reset();
        send_word(8'h01, ok);
        chk("irq_send1", 32'(ok), 1);
        chk("irq_one", 32'(bus.irq), 0);
        send_word(8'h02, ok);
        chk("irq_send2", 32'(ok), 1);
        chk("irq_two", 32'(bus.irq), 32'(IRQ_ON));
        cpu_read();
        chk("irq_after_rd", 32'(bus.irq), 0);

        // ---- randomized run against the reference model ----
        do_reset();
        for (int c = 0; c < 2400; c++) begin
            int rd_pct;
            int wr_pct;
            rd_pct = ((c / 300) % 2 == 0) ? 10 : 50;
            wr_pct = ((c / 300) % 2 == 0) ? 50 : 15;
            r_idr   = ($urandom_range(0, 99) < 70);
            r_idata = 8'($urandom);
            r_oack  = ($urandom_range(0, 99) < 45);
            r_wr    = ($urandom_range(0, 99) < wr_pct);
            r_wdata = 8'($urandom);
            r_rd    = ($urandom_range(0, 99) < rd_pct);
            r_clr   = ($urandom_range(0, 99) < 4);
            bus.inDataReady = r_idr; bus.in = r_idata; bus.outACK = r_oack;
            bus.cpu_wr = r_wr; bus.cpu_wdata = r_wdata;
            bus.cpu_rd = r_rd; bus.clr_err = r_clr;
            model_step();
            step();
            chk($sformatf("rnd%0d_inack", c), 32'(bus.inACK), 32'(m_in_busy));
            chk($sformatf("rnd%0d_odr", c), 32'(bus.outDataReady), 32'(m_ophase == 1));
            chk($sformatf("rnd%0d_out", c), 32'(bus.out), 32'(m_outv));
            chk($sformatf("rnd%0d_rdata", c), 32'(bus.cpu_rdata), 32'(m_rdata));
            chk($sformatf("rnd%0d_status", c), 32'(bus.status),
                32'({m_ovf, m_unf, m_out.size() == OD, m_in.size() == 0}));
            chk($sformatf("rnd%0d_irq", c), 32'(bus.irq), 32'(m_irq));
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/io_handshake_port.md
Name: io_handshake_port

Overview:
- Parametrised processor I/O port. Replaces the fixed single-byte in/out registers with buffered channels.
- Bridges the CPU-side register interface to an external device using a four-phase ready/ack handshake in each direction.
- Input FIFO and output FIFO decouple device timing from instruction timing.
- Raises an interrupt request toward the CPU interrupt controller.

Parameters:
DATA_W, 8, data width of both directions
IN_DEPTH, 4, input FIFO entries (power of 2, >=2)
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)
IRQ_THRESH, 1, input FIFO occupancy at or above which irq asserts (1..IN_DEPTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
in  in  DATA_W  external input data
inDataReady  in  1  external device has valid data on in
inACK  out  1  port has captured in
out  out  DATA_W  external output data
outDataReady  out  1  out is valid
outACK  in  1  external device has captured out
cpu_wr  in  1  push cpu_wdata into output FIFO
cpu_wdata  in  DATA_W  CPU write data
cpu_rd  in  1  pop input FIFO into cpu_rdata
cpu_rdata  out  DATA_W  registered read data
status  out  4  {ovf, unf, out_full, in_empty}
clr_err  in  1  clear sticky ovf/unf
irq  out  1  interrupt request, level

Behaviour:
- Reset (reset=0, async): both FIFOs empty; inACK=0, outDataReady=0, out=0, cpu_rdata=0, irq=0, ovf=0, unf=0. Status reads 4'b0001 (in_empty=1).
- Input FSM states: I_IDLE, I_ACK.
  - I_IDLE: when inDataReady=1 and the input FIFO is not full, push in and go to I_ACK, with inACK=1 from the next cycle.
  - If the input FIFO is full, wait in I_IDLE with inACK=0. No data is lost.
  - I_ACK: hold inACK=1 until inDataReady=0, then inACK=0 next cycle and return to I_IDLE.
  - A transfer therefore takes at least 3 cycles.
- Output FSM states: O_IDLE, O_VALID, O_WAITLOW.
  - O_IDLE: when the output FIFO is not empty, load out from the head and set outDataReady=1 next cycle (O_VALID).
  - O_VALID: on outACK=1, pop the head, drop outDataReady, go to O_WAITLOW.
  - O_WAITLOW: on outACK=0, go to O_IDLE.
  - out holds its last value after popping.
- CPU write:
  - cpu_wr with the output FIFO not full: push takes effect the same edge.
  - cpu_wr with the output FIFO full: data is discarded and ovf is set.
  - A simultaneous cpu_wr and output pop while full is accepted (the pop frees the slot).
- CPU read:
  - cpu_rd with the input FIFO not empty: cpu_rdata gets the head at the next edge (1-cycle latency) and the head is popped.
  - cpu_rd with the input FIFO empty: cpu_rdata is unchanged and unf is set.
  - A simultaneous input push and cpu_rd while empty is an underflow; the pushed data is retained.
- Sticky flags: clr_err clears ovf/unf. A same-cycle set takes priority over the clear.
- out_full and in_empty are combinational from the FIFO counts.
- FIFO occupancy counts are $clog2(depth)+1 bits wide. Pointers wrap modulo depth.
- Reset asserted mid-handshake aborts it: inACK and outDataReady drop immediately and the FIFOs are flushed.

Optional Feature:
- Macro: IO_PORT_IRQ_EN.
- Defined:
  - irq is registered, =1 when input occupancy >= IRQ_THRESH, or the output FIFO is empty after a prior non-empty cycle (tx-done).
  - tx-done clears on cpu_wr or clr_err.
- Undefined: irq is tied to 0 and no irq logic is synthesised. status is unaffected.

Test Plan:
- Reset then release → inACK=0, outDataReady=0, cpu_rdata=0, status=4'b0001, irq=0.
- Device sends 0x5A via four-phase → inACK rises 1 cycle after inDataReady. Then cpu_rd → cpu_rdata=0x5A next cycle, in_empty=1.
- CPU writes 0x11,0x22,0x33,0x44,0x55 with outACK held 0 (IN/OUT_DEPTH=4):
  - first write enters O_VALID with out=0x11;
  - fifth write sets ovf, status[3]=1;
  - acking all words yields 0x11,0x22,0x33,0x44 in order, and 0x55 never appears.
- Device offers 5 words with no cpu_rd (depth 4) → four acks. Fifth: inACK stays 0 until one cpu_rd, then it is accepted.
- cpu_rd on empty → unf=1, cpu_rdata unchanged. Then clr_err → unf=0.
- IO_PORT_IRQ_EN, IRQ_THRESH=2:
  - one word in → irq=0; second word → irq=1; one cpu_rd → irq=0 next cycle.
  - Without the macro, irq=0 throughout.
